truth_table_sweeper: RTL

- Sequential characterizer: the reading end of a 3-input truth-table gate.
- Drives every input combination into a combinational logic block under test (DUT), waits for it to settle, and samples its output.
- Assembles the 8-bit truth-table code (e.g. 0x9A) and compares it with an expected code.
- Sits in the verification/bring-up harness next to the compiled gate netlists; one instance per DUT.

---
 rtl/truth_table_sweeper_pkg.sv | 26 ++
 rtl/truth_table_sweeper_timer.sv | 31 +++
 rtl/truth_table_sweeper.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and helpers for the truth-table sweeper and anything that
// needs to agree with it on row-to-bit ordering.
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } sweep_state_e;

    // Truth-table width for a given number of DUT inputs.
    function automatic int tt_width(input int n_in);
        return 1 << n_in;
    endfunction

    // Row 0 lands in the MSB of the code, so the last row lands in bit 0.
    function automatic int row_bit_index(input int n_in, input int r);
        return tt_width(n_in) - 1 - r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_timer.sv
// Loadable down-counter shared by the settle and sample windows.
// The counter parks at zero; tc_o flags the last cycle of a window.
module truth_table_sweeper_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    // Load has priority over counting so a window can restart on its final cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks every input combination of a combinational
// gate, lets it settle, samples its output and assembles the table code.
//
//   state  | meaning
//   IDLE   | waiting for start, results held
//   SETTLE | stim driven for the current row, output not yet trusted
//   SAMPLE | dut_out captured each cycle, first sample -> tt, changes -> unstable
//   DONE   | one-cycle done pulse, match resolved
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLE_CYCLES = 2,
    localparam int TT_W         = 1 << N_IN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [TT_W-1:0] exp_tt,
    input  logic            dut_out,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] tt,
    output logic [TT_W-1:0] unstable,
    output logic            match
);

    localparam int TMR_W = $clog2(max2(SETTLE_CYCLES, SAMPLE_CYCLES) + 1);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] SAMPLE_LD = TMR_W'(SAMPLE_CYCLES - 1);
    localparam logic [N_IN-1:0]  ROW_LAST  = N_IN'(TT_W - 1);

    sweep_state_e    state_q, state_d;
    logic [N_IN-1:0] row_q, row_d;
    logic [TT_W-1:0] exp_q, exp_d;
    logic [TT_W-1:0] tt_q, tt_d;
    logic [TT_W-1:0] unst_q, unst_d;
    logic            match_q, match_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_ld_val;
    logic             tmr_en;
    logic [TMR_W-1:0] tmr_cnt;
    logic             tmr_tc;

    logic [N_IN-1:0] bit_idx;
    logic            done_match;

    assign bit_idx    = N_IN'(row_bit_index(N_IN, int'(row_q)));
    assign done_match = (tt_q == exp_q) && (unst_q == '0);

    truth_table_sweeper_timer #(
        .W (TMR_W)
    ) u_sweep_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_ld_val),
        .en_i       (tmr_en),
        .cnt_o      (tmr_cnt),
        .tc_o       (tmr_tc)
    );

    // State and result registers; reset wipes any partial sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            exp_q   <= '0;
            tt_q    <= '0;
            unst_q  <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            exp_q   <= exp_d;
            tt_q    <= tt_d;
            unst_q  <= unst_d;
            match_q <= match_d;
        end
    end

    // Sequencing, per-row sampling and timer reloads on every state change.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        exp_d      = exp_q;
        tt_d       = tt_q;
        unst_d     = unst_q;
        match_d    = match_q;
        tmr_load   = 1'b0;
        tmr_ld_val = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d      = exp_tt;
                    tt_d       = '0;
                    unst_d     = '0;
                    match_d    = 1'b0;
                    row_d      = '0;
                    tmr_load   = 1'b1;
                    tmr_ld_val = SETTLE_LD;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                if (tmr_tc) begin
                    tmr_load   = 1'b1;
                    tmr_ld_val = SAMPLE_LD;
                    state_d    = SAMPLE;
                end
            end
            SAMPLE: begin
                if (tmr_cnt == SAMPLE_LD) begin
                    tt_d[bit_idx] = dut_out;
                end else if (dut_out != tt_q[bit_idx]) begin
                    unst_d[bit_idx] = 1'b1;
                end
                if (tmr_tc) begin
                    tmr_load = 1'b1;
                    if (row_q == ROW_LAST) begin
                        tmr_ld_val = '0;
                        state_d    = DONE;
                    end else begin
                        row_d      = row_q + N_IN'(1);
                        tmr_ld_val = SETTLE_LD;
                        state_d    = SETTLE;
                    end
                end
            end
            DONE: begin
                match_d    = done_match;
                tmr_load   = 1'b1;
                tmr_ld_val = '0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done     = (state_q == DONE);
    assign tmr_en   = busy;
    assign stim     = busy ? row_q : '0;
    assign tt       = tt_q;
    assign unstable = unst_q;
    // match is already valid during the done pulse, then held from the register.
    assign match    = done ? done_match : match_q;

endmodule
